// File: rtl/safety_fsm_mc.sv
// Multi-channel safety FSM: per-channel escalation/hysteresis with latched EMERGENCY/FAILSAFE and a worst-case reduction.
// Optional per-channel sample watchdog is built only when SAFETY_FSM_WDT_EN is defined.
module safety_fsm_mc #(
    parameter int unsigned N_CH     = 4,
    parameter int unsigned ESC_CNT  = 3,
    parameter int unsigned HYST_CYC = 8,
    parameter int unsigned WDT_CYC  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       sample_valid,
    input  logic [N_CH-1:0]       ml_anomaly,
    input  logic [N_CH-1:0]       sensor_fault,
    input  logic                  clear_req,
    input  logic [N_CH-1:0]       clear_mask,
    output logic [3*N_CH-1:0]     ch_state,
    output logic [N_CH-1:0]       state_chg,
    output logic [2:0]            sys_state,
    output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] worst_ch,
    output logic                  alarm,
    output logic                  clear_ack
);
    localparam int unsigned ESC_W = (ESC_CNT > 1) ? $clog2(ESC_CNT) : 1;
    localparam int unsigned CLN_W = (HYST_CYC > 1) ? $clog2(HYST_CYC) : 1;
    localparam int unsigned WCH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WARNING   = 3'd1;
    localparam logic [2:0] ST_CRITICAL  = 3'd2;
    localparam logic [2:0] ST_EMERGENCY = 3'd3;
    localparam logic [2:0] ST_FAILSAFE  = 3'd4;

    logic [2:0]       r_st      [N_CH];
    logic [2:0]       w_st_nxt  [N_CH];
    logic [ESC_W-1:0] r_esc     [N_CH];
    logic [ESC_W-1:0] w_esc_nxt [N_CH];
    logic [CLN_W-1:0] r_cln     [N_CH];
    logic [CLN_W-1:0] w_cln_nxt [N_CH];
    logic [N_CH-1:0]  w_fault;
    logic [N_CH-1:0]  w_rel;
    logic [N_CH-1:0]  r_chg;
    logic             r_ack;

`ifdef SAFETY_FSM_WDT_EN
    localparam int unsigned WDT_W = $clog2(WDT_CYC + 1);
    logic [WDT_W-1:0] r_wdt     [N_CH];
    logic [WDT_W-1:0] w_wdt_nxt [N_CH];

    // An expired watchdog acts as a fault unless a sample arrives this cycle to re-arm it
    always_comb begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            w_wdt_nxt[i] = r_wdt[i];
            if (sample_valid[i])
                w_wdt_nxt[i] = '0;
            else if (r_wdt[i] != WDT_W'(WDT_CYC))
                w_wdt_nxt[i] = r_wdt[i] + WDT_W'(1);
            w_fault[i] = sensor_fault[i] |
                         ((r_wdt[i] == WDT_W'(WDT_CYC)) & ~sample_valid[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_CH; i++) r_wdt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) r_wdt[i] <= w_wdt_nxt[i];
        end
    end
`else
    always_comb w_fault = sensor_fault;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                r_st[i]  <= ST_IDLE;
                r_esc[i] <= '0;
                r_cln[i] <= '0;
            end
            r_chg <= '0;
            r_ack <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                r_st[i]  <= w_st_nxt[i];
                r_esc[i] <= w_esc_nxt[i];
                r_cln[i] <= w_cln_nxt[i];
                r_chg[i] <= (w_st_nxt[i] != r_st[i]);
            end
            r_ack <= |w_rel;
        end
    end

    // Next-state: fault > latched hold/release > anomaly > clean > no sample
    always_comb begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            w_st_nxt[i]  = r_st[i];
            w_esc_nxt[i] = r_esc[i];
            w_cln_nxt[i] = r_cln[i];
            w_rel[i]     = 1'b0;
            if (w_fault[i]) begin
                w_st_nxt[i]  = ST_FAILSAFE;
                w_esc_nxt[i] = '0;
                w_cln_nxt[i] = '0;
            end else if (r_st[i] == ST_EMERGENCY || r_st[i] == ST_FAILSAFE) begin
                if (clear_req && clear_mask[i] && !(sample_valid[i] && ml_anomaly[i])) begin
                    w_st_nxt[i]  = ST_IDLE;
                    w_esc_nxt[i] = '0;
                    w_cln_nxt[i] = '0;
                    w_rel[i]     = 1'b1;
                end
            end else if (sample_valid[i] && ml_anomaly[i]) begin
                w_cln_nxt[i] = '0;
                if (r_esc[i] == ESC_W'(ESC_CNT - 1)) begin
                    w_st_nxt[i]  = r_st[i] + 3'd1;
                    w_esc_nxt[i] = '0;
                end else begin
                    w_esc_nxt[i] = r_esc[i] + ESC_W'(1);
                end
            end else if (sample_valid[i]) begin
                w_esc_nxt[i] = '0;
                if (r_st[i] == ST_WARNING || r_st[i] == ST_CRITICAL) begin
                    if (r_cln[i] == CLN_W'(HYST_CYC - 1)) begin
                        w_st_nxt[i]  = r_st[i] - 3'd1;
                        w_cln_nxt[i] = '0;
                    end else begin
                        w_cln_nxt[i] = r_cln[i] + CLN_W'(1);
                    end
                end else begin
                    w_cln_nxt[i] = '0;
                end
            end
        end
    end

    // Outputs: flattened state, pulses, and worst-case reduction (ties to lowest index)
    always_comb begin
        sys_state = ST_IDLE;
        worst_ch  = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            ch_state[3*i +: 3] = r_st[i];
            if (r_st[i] > sys_state) begin
                sys_state = r_st[i];
                worst_ch  = WCH_W'(i);
            end
        end
        alarm     = (sys_state >= ST_CRITICAL);
        state_chg = r_chg;
        clear_ack = r_ack;
    end
endmodule
